// File: rtl/dlatch_pkg.sv
// rtl/dlatch_pkg.sv - shared FSM encoding and coverage indices for the D-latch checker
package dlatch_pkg;

  typedef enum logic [1:0] {
    S_UNKNOWN = 2'd0,
    S_TRACK   = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam int COV_W      = 4;
  localparam int COV_TRANS0 = 0;
  localparam int COV_TRANS1 = 1;
  localparam int COV_HOLD0  = 2;
  localparam int COV_HOLD1  = 3;

  // One-hot coverage bit for a check: transparent samples index by d, hold samples by the model value.
  function automatic logic [COV_W-1:0] cov_bit(input logic transparent, input logic value);
    logic [COV_W-1:0] bits;
    bits = '0;
    if (transparent) begin
      if (value) bits[COV_TRANS1] = 1'b1;
      else       bits[COV_TRANS0] = 1'b1;
    end else begin
      if (value) bits[COV_HOLD1] = 1'b1;
      else       bits[COV_HOLD0] = 1'b1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/dlatch_checker_sat_counter.sv
// rtl/dlatch_checker_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic [W-1:0] count_nxt
);

  always_comb begin
    count_nxt = count;
    if (clr) begin
      count_nxt = '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count_nxt = count + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/dlatch_checker.sv
// rtl/dlatch_checker.sv - two-stage monitor comparing an observed D latch against a reference model
module dlatch_checker
  import dlatch_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int MIN_CHECKS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             d,
  input  logic             q,
  input  logic             clr,
  output logic             mismatch,
  output logic             fail,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       cov,
  output logic             done
);

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_CHECKS);

  logic             en_s;
  logic             d_s;
  logic             q_s;
  state_t           state;
  state_t           state_nxt;
  logic             model;
  logic             is_hold;
  logic             check_valid;
  logic             expected;
  logic             miss;
  logic [3:0]       cov_nxt;
  logic [CNT_W-1:0] chk_nxt;
  logic [CNT_W-1:0] err_nxt;

  // Hold samples are only meaningful once a transparent sample has fixed the model.
  always_comb begin
    is_hold     = !en_s && (state != S_UNKNOWN);
    check_valid = !clr && (en_s || is_hold);
    expected    = en_s ? d_s : model;
    miss        = check_valid && (q_s != expected);
    cov_nxt     = '0;
    if (!clr) begin
      cov_nxt = cov | (check_valid ? cov_bit(en_s, expected) : 4'b0000);
    end
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = S_UNKNOWN;
    end else begin
      case (state)
        S_UNKNOWN: if (en_s) state_nxt = S_TRACK;
        S_TRACK:   if ((cov_nxt == 4'b1111) && (chk_nxt >= MIN_C)) state_nxt = S_DONE;
        S_DONE:    state_nxt = S_DONE;
        default:   state_nxt = S_UNKNOWN;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_chk_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (check_valid),
    .clr       (clr),
    .count     (chk_cnt),
    .count_nxt (chk_nxt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (miss),
    .clr       (clr),
    .count     (err_cnt),
    .count_nxt (err_nxt)
  );

  // clr leaves the sample stage alone so the sample taken alongside clr is still evaluated next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_s     <= 1'b0;
      d_s      <= 1'b0;
      q_s      <= 1'b0;
      state    <= S_UNKNOWN;
      model    <= 1'b0;
      cov      <= '0;
      fail     <= 1'b0;
      mismatch <= 1'b0;
      done     <= 1'b0;
    end else begin
      en_s     <= en;
      d_s      <= d;
      q_s      <= q;
      state    <= state_nxt;
      cov      <= cov_nxt;
      mismatch <= miss;
      done     <= (state_nxt == S_DONE);
      if (clr) begin
        model <= 1'b0;
        fail  <= 1'b0;
      end else begin
        if (en_s) model <= d_s;
        if (miss) fail  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dlatch_checker.sv
// tb/tb_dlatch_checker.sv - randomized bench for dlatch_checker against a queue-free behavioural latch monitor model
module tb_dlatch_checker;

  logic       clk = 1'b0;
  logic       rst_n, en, d, q, clr;
  logic       mis_a, fail_a, done_a;
  logic [7:0] chk_a, err_a;
  logic [3:0] cov_a;
  logic       mis_b, fail_b, done_b;
  logic [2:0] chk_b, err_b;
  logic [3:0] cov_b;

  dlatch_checker u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .d(d), .q(q), .clr(clr),
    .mismatch(mis_a), .fail(fail_a), .chk_cnt(chk_a), .err_cnt(err_a),
    .cov(cov_a), .done(done_a)
  );

  dlatch_checker #(.CNT_W(3), .MIN_CHECKS(6)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .d(d), .q(q), .clr(clr),
    .mismatch(mis_b), .fail(fail_b), .chk_cnt(chk_b), .err_cnt(err_b),
    .cov(cov_b), .done(done_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: latch state known/unknown, model value, unbounded counts saturated only when compared.
  bit       p_en, p_d, p_q;
  bit       m_known, m_val, m_fail, m_mis;
  bit [3:0] m_cov;
  int       m_chk, m_err;
  bit       m_done [2];
  int       lim  [2] = '{255, 7};
  int       minc [2] = '{8, 6};
  bit       lat_q;

  function automatic int sat(input int v, input int l);
    return (v > l) ? l : v;
  endfunction

  task automatic model_reset();
    p_en = 0; p_d = 0; p_q = 0;
    m_known = 0; m_val = 0; m_fail = 0; m_mis = 0;
    m_cov = 0; m_chk = 0; m_err = 0;
    m_done[0] = 0; m_done[1] = 0;
  endtask

  task automatic model_edge(input bit e, input bit dd, input bit qq, input bit c);
    bit checked, expv;
    int idx;
    if (c) begin
      m_known = 0; m_val = 0; m_fail = 0; m_mis = 0;
      m_cov = 0; m_chk = 0; m_err = 0;
      m_done[0] = 0; m_done[1] = 0;
    end else begin
      checked = 0; expv = 0; idx = 0;
      if (p_en) begin
        checked = 1; expv = p_d; idx = p_d ? 1 : 0;
      end else if (m_known) begin
        checked = 1; expv = m_val; idx = m_val ? 3 : 2;
      end
      m_mis = 0;
      if (checked) begin
        m_chk++;
        m_cov[idx] = 1'b1;
        if (p_q != expv) begin
          m_mis = 1; m_err++; m_fail = 1;
        end
      end
      for (int i = 0; i < 2; i++)
        if (m_known && !m_done[i] && m_cov == 4'hf && sat(m_chk, lim[i]) >= minc[i])
          m_done[i] = 1;
      if (p_en) begin
        m_known = 1; m_val = p_d;
      end
    end
    p_en = e; p_d = dd; p_q = qq;
  endtask

  task automatic check_outputs(input string ctx);
    check({ctx, ".a.mis"},  mis_a,  m_mis);
    check({ctx, ".a.fail"}, fail_a, m_fail);
    check({ctx, ".a.chk"},  chk_a,  sat(m_chk, lim[0]));
    check({ctx, ".a.err"},  err_a,  sat(m_err, lim[0]));
    check({ctx, ".a.cov"},  cov_a,  m_cov);
    check({ctx, ".a.done"}, done_a, m_done[0]);
    check({ctx, ".b.mis"},  mis_b,  m_mis);
    check({ctx, ".b.fail"}, fail_b, m_fail);
    check({ctx, ".b.chk"},  chk_b,  sat(m_chk, lim[1]));
    check({ctx, ".b.err"},  err_b,  sat(m_err, lim[1]));
    check({ctx, ".b.cov"},  cov_b,  m_cov);
    check({ctx, ".b.done"}, done_b, m_done[1]);
  endtask

  task automatic step(input bit e, input bit dd, input bit qq, input bit c);
    @(negedge clk);
    en = e; d = dd; q = qq; clr = c;
    @(posedge clk);
    model_edge(e, dd, qq, c);
    #1;
    check_outputs("step");
  endtask

  // Drives an ideal latch; corrupt inverts the observed q for this cycle.
  task automatic latch_step(input bit e, input bit dd, input bit corrupt, input bit c);
    if (e) lat_q = dd;
    step(e, dd, corrupt ? ~lat_q : lat_q, c);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 0;
    #1;
    model_reset();
    check_outputs("rst_async");
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      q = ~q; en = 1'($urandom); d = 1'($urandom);
      @(posedge clk);
      #1;
      check_outputs("rst_hold");
    end
    @(negedge clk);
    rst_n = 1; en = 0; d = 0; q = 0; clr = 0; lat_q = 0;
    @(posedge clk);
    model_edge(0, 0, 0, 0);
    #1;
    check_outputs("rst_rel");
  endtask

  initial begin
    bit [2:0] sv;
    rst_n = 0; en = 0; d = 0; q = 0; clr = 0; lat_q = 0;
    model_reset();
    do_reset(4);

    repeat (5) latch_step(0, 0, 0, 0);
    check("idle_chk", chk_a, 0);
    check("idle_cov", cov_a, 0);

    for (int s = 0; s < 16; s++) begin
      sv = 3'(s);
      latch_step(sv[2] ^ sv[0], sv[1], 0, 0);
    end
    check("pat_done", done_a, 1);
    check("pat_cov",  cov_a, 4'hf);
    check("pat_err",  err_a, 0);
    check("pat_fail", fail_a, 0);

    latch_step(1, 1, 1, 0);
    check("sa_mis_n", mis_a, 0);
    latch_step(1, 1, 0, 0);
    check("sa_mis_n1", mis_a, 1);
    check("sa_err",    err_a, 1);
    check("sa_fail",   fail_a, 1);
    check("sa_done",   done_a, 1);
    latch_step(1, 1, 0, 0);
    check("sa_mis_n2", mis_a, 0);

    latch_step(1, 1, 0, 0);
    latch_step(0, 0, 1, 0);
    latch_step(0, 0, 0, 0);
    check("hold_mis",  mis_a, 1);
    check("hold_cov3", cov_a[3], 1);
    check("hold_err",  err_a, 2);

    latch_step(1, 0, 0, 1);
    repeat (13) latch_step(1, 1'($urandom), 1, 0);
    latch_step(0, 0, 0, 0);
    check("sat_err_a", err_a, 13);
    check("sat_err_b", err_b, 7);
    check("sat_chk_b", chk_b, 7);
    check("sat_mis_b", mis_b, 1);

    latch_step(1, 1, 1, 0);
    latch_step(1, 0, 0, 1);
    check("clr_mis",  mis_a, 0);
    check("clr_err",  err_a, 0);
    check("clr_fail", fail_a, 0);
    check("clr_done", done_a, 0);
    latch_step(0, 0, 0, 0);
    check("clr_next_chk", chk_a, 1);
    check("clr_next_mis", mis_a, 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < 2) begin
        do_reset(1);
      end else begin
        latch_step(1'($urandom), 1'($urandom),
                   $urandom_range(99) < 15, $urandom_range(99) < 4);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
